// File: rtl/ldm_stm_seq.sv
// LDM/STM multi-register transfer sequencer: walks the register list, issues one
// word transfer per listed register, then optionally writes back the base.
module ldm_stm_seq #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [15:0]   reglist,
  input  logic [3:0]    rn,
  input  logic [AW-1:0] base,
  input  logic          p_bit,
  input  logic          u_bit,
  input  logic          w_bit,
  input  logic          l_bit,
  output logic          busy,
  output logic          done,
  output logic [3:0]    rf_ra2,
  input  logic [DW-1:0] rf_rd2,
  output logic          rf_we3,
  output logic [3:0]    rf_wa3,
  output logic [DW-1:0] rf_wd3,
  output logic          pc_we,
  output logic [DW-1:0] pc_wd,
  output logic          mem_req,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [2:0] {IDLE, CALC, XFER, WB, DONE} state_t;

  state_t        state, state_nxt;
  logic [15:0]   list_q, mask_q, mask_clr;
  logic [3:0]    rn_q, cur;
  logic [AW-1:0] base_q, addr_q, wbv_q, span;
  logic          p_q, u_q, w_q, l_q;
  logic [4:0]    n;

  always_comb begin
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(list_q[i]);
  end

  assign span = AW'({n, 2'b00});

  // Descending scan so the lowest set bit wins.
  always_comb begin
    cur = '0;
    for (int i = 15; i >= 0; i--) if (mask_q[i]) cur = 4'(i);
  end

  assign mask_clr = mask_q & ~(16'd1 << cur);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      list_q <= '0;
      mask_q <= '0;
      rn_q   <= '0;
      base_q <= '0;
      addr_q <= '0;
      wbv_q  <= '0;
      p_q    <= 1'b0;
      u_q    <= 1'b0;
      w_q    <= 1'b0;
      l_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          list_q <= reglist;
          rn_q   <= rn;
          base_q <= base;
          p_q    <= p_bit;
          u_q    <= u_bit;
          w_q    <= w_bit;
          l_q    <= l_bit;
        end
        CALC: begin
          mask_q <= list_q;
          // Descending modes start low so transfers always climb in address.
          case ({p_q, u_q})
            2'b01:   addr_q <= base_q;
            2'b11:   addr_q <= base_q + AW'(4);
            2'b00:   addr_q <= base_q - span + AW'(4);
            default: addr_q <= base_q - span;
          endcase
          wbv_q <= u_q ? base_q + span : base_q - span;
        end
        XFER: if (mem_ready) begin
          mask_q <= mask_clr;
          addr_q <= addr_q + AW'(4);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    rf_we3    = 1'b0;
    rf_wa3    = cur;
    rf_wd3    = mem_rdata;
    pc_we     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        if (n != 5'd0)  state_nxt = XFER;
        else if (w_q)   state_nxt = WB;
        else            state_nxt = DONE;
      end
      XFER: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          if (l_q) begin
            if (cur == 4'd15) pc_we  = 1'b1;
            else              rf_we3 = 1'b1;
          end
          // A loaded base overrides the writeback.
          if (mask_clr == 16'd0)
            state_nxt = (w_q && !(l_q && list_q[rn_q])) ? WB : DONE;
        end
      end
      WB: begin
        rf_we3    = 1'b1;
        rf_wa3    = rn_q;
        rf_wd3    = DW'(wbv_q);
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign mem_write = ~l_q;
  assign mem_addr  = addr_q;
  assign rf_ra2    = cur;
  assign mem_wdata = rf_rd2;
  assign pc_wd     = mem_rdata;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: memory responder with programmable wait states,
// a monitor logging register/PC/memory traffic, and per-scenario checking tasks.
module tb_ldm_stm_seq;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [15:0]   reglist = '0;
  logic [3:0]    rn = '0;
  logic [AW-1:0] base = '0;
  logic          p_bit = 1'b0, u_bit = 1'b0, w_bit = 1'b0, l_bit = 1'b0;
  logic          busy, done, rf_we3, pc_we, mem_req, mem_write;
  logic [3:0]    rf_ra2, rf_wa3;
  logic [DW-1:0] rf_rd2, rf_wd3, pc_wd, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_ready = 1'b0;

  ldm_stm_seq #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .reglist(reglist), .rn(rn),
    .base(base), .p_bit(p_bit), .u_bit(u_bit), .w_bit(w_bit), .l_bit(l_bit),
    .busy(busy), .done(done), .rf_ra2(rf_ra2), .rf_rd2(rf_rd2),
    .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3), .pc_we(pc_we), .pc_wd(pc_wd),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Register file read model: Rx reads as 0xC0DE000x.
  assign rf_rd2 = 32'hC0DE_0000 | {28'd0, rf_ra2};

  int checks = 0, errors = 0;
  int wait_n = 0, cnt = 0;
  logic [DW-1:0] rq[$];
  logic [3:0]    wa_q[$];
  logic [DW-1:0] wd_q[$], pc_q[$], mwd_q[$];
  logic [AW-1:0] ma_q[$];
  logic          mw_q[$];
  int            hold_err = 0, r15_wr = 0;
  logic          hold_v = 1'b0;
  logic [AW-1:0] hold_a = '0;
  logic [DW-1:0] hold_d = '0;

  // Memory responder: wait_n idle cycles per transfer, then one ready cycle.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (cnt >= wait_n) begin
        mem_ready = 1'b1;
        mem_rdata = (rq.size() > 0) ? rq.pop_front() : 32'h0;
        cnt = 0;
      end else begin
        mem_ready = 1'b0;
        cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (mem_req && mem_ready) begin
      ma_q.push_back(mem_addr); mw_q.push_back(mem_write); mwd_q.push_back(mem_wdata);
    end
    if (mem_req) begin
      if (hold_v && (mem_addr !== hold_a || mem_wdata !== hold_d)) hold_err++;
      hold_v = !mem_ready; hold_a = mem_addr; hold_d = mem_wdata;
    end else hold_v = 1'b0;
    if (rf_we3) begin
      wa_q.push_back(rf_wa3); wd_q.push_back(rf_wd3);
      if (rf_wa3 == 4'd15) r15_wr++;
    end
    if (pc_we) pc_q.push_back(pc_wd);
  end

  task automatic clear_logs;
    wa_q.delete(); wd_q.delete(); pc_q.delete(); ma_q.delete(); mw_q.delete(); mwd_q.delete();
    hold_err = 0; r15_wr = 0;
  endtask

  // Pulse start; edges = index of the edge (after the start edge) that sees done high.
  task automatic launch(input logic [15:0] rl, input logic [3:0] r, input logic [AW-1:0] b,
                        input logic p, input logic u, input logic w, input logic l,
                        output int edges);
    @(posedge clk); #1;
    reglist = rl; rn = r; base = b; p_bit = p; u_bit = u; w_bit = w; l_bit = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    forever begin
      @(negedge clk);
      edges++;
      if (done) break;
      if (edges > 200) begin edges = -1; break; end
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (rf_we3 !== 1'b0)  begin errors++; $display("FAIL reset_rf_we3 got %b exp 0", rf_we3); end
    checks++; if (pc_we !== 1'b0)   begin errors++; $display("FAIL reset_pc_we got %b exp 0", pc_we); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_ldmia;
    int e;
    logic [AW-1:0] ea[3]  = '{32'h1000, 32'h1004, 32'h1008};
    logic [3:0]    ewa[4] = '{4'd1, 4'd2, 4'd3, 4'd13};
    logic [DW-1:0] ewd[4] = '{32'hA1, 32'hA2, 32'hA3, 32'h100C};
    clear_logs(); wait_n = 0; rq = '{32'hA1, 32'hA2, 32'hA3};
    launch(16'h000E, 4'd13, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b1, e);
    checks++; if (e !== 6) begin errors++; $display("FAIL ldmia_done_edge got %0d exp 6", e); end
    checks++; if (ma_q.size() !== 3) begin errors++; $display("FAIL ldmia_nxfer got %0d exp 3", ma_q.size()); end
    for (int i = 0; i < 3 && i < ma_q.size(); i++) begin
      checks++; if (ma_q[i] !== ea[i] || mw_q[i] !== 1'b0) begin errors++;
        $display("FAIL ldmia_addr[%0d] got %h/w%b exp %h/w0", i, ma_q[i], mw_q[i], ea[i]); end
    end
    checks++; if (wa_q.size() !== 4) begin errors++; $display("FAIL ldmia_nwr got %0d exp 4", wa_q.size()); end
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      checks++; if (wa_q[i] !== ewa[i] || wd_q[i] !== ewd[i]) begin errors++;
        $display("FAIL ldmia_wr[%0d] got R%0d=%h exp R%0d=%h", i, wa_q[i], wd_q[i], ewa[i], ewd[i]); end
    end
    checks++; if (pc_q.size() !== 0) begin errors++; $display("FAIL ldmia_pc_we got %0d exp 0", pc_q.size()); end
  endtask

  task automatic test_stmdb_wait;
    int e;
    logic [AW-1:0] ea[2] = '{32'h1FF8, 32'h1FFC};
    logic [DW-1:0] ed[2] = '{32'hC0DE0004, 32'hC0DE000E};
    clear_logs(); wait_n = 2; rq.delete();
    launch(16'h4010, 4'd0, 32'h2000, 1'b1, 1'b0, 1'b1, 1'b0, e);
    checks++; if (e !== 9) begin errors++; $display("FAIL stmdb_done_edge got %0d exp 9", e); end
    checks++; if (ma_q.size() !== 2) begin errors++; $display("FAIL stmdb_nxfer got %0d exp 2", ma_q.size()); end
    for (int i = 0; i < 2 && i < ma_q.size(); i++) begin
      checks++; if (ma_q[i] !== ea[i] || mwd_q[i] !== ed[i] || mw_q[i] !== 1'b1) begin errors++;
        $display("FAIL stmdb_st[%0d] got %h:%h w%b exp %h:%h w1", i, ma_q[i], mwd_q[i], mw_q[i], ea[i], ed[i]); end
    end
    checks++; if (hold_err !== 0) begin errors++; $display("FAIL stmdb_hold got %0d changes exp 0", hold_err); end
    checks++; if (wa_q.size() !== 1) begin errors++; $display("FAIL stmdb_nwr got %0d exp 1", wa_q.size()); end
    else begin
      checks++; if (wa_q[0] !== 4'd0 || wd_q[0] !== 32'h1FF8) begin errors++;
        $display("FAIL stmdb_wb got R%0d=%h exp R0=00001ff8", wa_q[0], wd_q[0]); end
    end
    wait_n = 0;
  endtask

  task automatic test_ldmib_pc;
    int e;
    clear_logs(); wait_n = 0; rq = '{32'h11111111, 32'h22222222};
    launch(16'h8001, 4'd1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b1, e);
    checks++; if (e !== 4) begin errors++; $display("FAIL ldmib_done_edge got %0d exp 4", e); end
    checks++; if (ma_q.size() !== 2) begin errors++; $display("FAIL ldmib_nxfer got %0d exp 2", ma_q.size()); end
    else begin
      checks++; if (ma_q[0] !== 32'h104 || ma_q[1] !== 32'h108) begin errors++;
        $display("FAIL ldmib_addr got %h,%h exp 00000104,00000108", ma_q[0], ma_q[1]); end
    end
    checks++; if (wa_q.size() !== 1) begin errors++; $display("FAIL ldmib_nwr got %0d exp 1", wa_q.size()); end
    else begin
      checks++; if (wa_q[0] !== 4'd0 || wd_q[0] !== 32'h11111111) begin errors++;
        $display("FAIL ldmib_r0 got R%0d=%h exp R0=11111111", wa_q[0], wd_q[0]); end
    end
    checks++; if (r15_wr !== 0) begin errors++; $display("FAIL ldmib_r15_rfwr got %0d exp 0", r15_wr); end
    checks++; if (pc_q.size() !== 1) begin errors++; $display("FAIL ldmib_npc got %0d exp 1", pc_q.size()); end
    else begin
      checks++; if (pc_q[0] !== 32'h22222222) begin errors++; $display("FAIL ldmib_pc got %h exp 22222222", pc_q[0]); end
    end
  endtask

  task automatic test_base_in_list;
    int e;
    clear_logs(); wait_n = 0; rq = '{32'hB1, 32'hB2};
    launch(16'h0006, 4'd2, 32'h3000, 1'b0, 1'b1, 1'b1, 1'b1, e);
    checks++; if (e !== 4) begin errors++; $display("FAIL rnlist_done_edge got %0d exp 4", e); end
    checks++; if (wa_q.size() !== 2) begin errors++; $display("FAIL rnlist_nwr got %0d exp 2", wa_q.size()); end
    else begin
      checks++; if (wa_q[1] !== 4'd2 || wd_q[1] !== 32'hB2 || wa_q[0] !== 4'd1 || wd_q[0] !== 32'hB1) begin errors++;
        $display("FAIL rnlist_wr got R%0d=%h,R%0d=%h exp R1=b1,R2=b2", wa_q[0], wd_q[0], wa_q[1], wd_q[1]); end
    end
  endtask

  task automatic test_empty_and_busy_start;
    int e;
    clear_logs(); wait_n = 0; rq.delete();
    @(posedge clk); #1;
    reglist = 16'h0000; rn = 4'd7; base = 32'h40; p_bit = 1'b0; u_bit = 1'b0; w_bit = 1'b1; l_bit = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    // Keep start high with a different list while busy; it must be ignored.
    reglist = 16'hFFFF; w_bit = 1'b0;
    e = 0;
    forever begin
      @(negedge clk);
      e++;
      if (done) begin start = 1'b0; break; end
      if (e > 200) begin e = -1; start = 1'b0; break; end
    end
    checks++; if (e !== 3) begin errors++; $display("FAIL empty_done_edge got %0d exp 3", e); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy_after got %b exp 0", busy); end
    checks++; if (ma_q.size() !== 0) begin errors++; $display("FAIL empty_nxfer got %0d exp 0", ma_q.size()); end
    checks++; if (wa_q.size() !== 1) begin errors++; $display("FAIL empty_nwr got %0d exp 1", wa_q.size()); end
    else begin
      checks++; if (wa_q[0] !== 4'd7 || wd_q[0] !== 32'h40) begin errors++;
        $display("FAIL empty_wb got R%0d=%h exp R7=00000040", wa_q[0], wd_q[0]); end
    end
  endtask

  task automatic test_reset_mid_xfer;
    int e;
    clear_logs(); wait_n = 0; rq = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
    @(posedge clk); #1;
    reglist = 16'h00F0; rn = 4'd9; base = 32'h500; p_bit = 1'b0; u_bit = 1'b1; w_bit = 1'b1; l_bit = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h504) begin errors++;
      $display("FAIL rst_pre got req%b %h exp req1 00000504", mem_req, mem_addr); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (rf_we3 !== 1'b0)  begin errors++; $display("FAIL rst_rf_we3 got %b exp 0", rf_we3); end
    clear_logs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL rst_writes got %0d exp 0", wa_q.size()); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle got busy %b exp 0", busy); end
    rq.delete(); rq = '{32'h77};
    launch(16'h0001, 4'd0, 32'h10, 1'b0, 1'b1, 1'b0, 1'b1, e);
    checks++; if (e !== 3) begin errors++; $display("FAIL rst_restart_edge got %0d exp 3", e); end
    checks++; if (wa_q.size() !== 1) begin errors++; $display("FAIL rst_restart_nwr got %0d exp 1", wa_q.size()); end
    else begin
      checks++; if (wa_q[0] !== 4'd0 || wd_q[0] !== 32'h77) begin errors++;
        $display("FAIL rst_restart_wr got R%0d=%h exp R0=00000077", wa_q[0], wd_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_ldmia();
    test_stmdb_wait();
    test_ldmib_pc();
    test_base_in_list();
    test_empty_and_busy_start();
    test_reset_mid_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
